div_unit: RTL

- Iterative multi-cycle divide/remainder unit in the EX stage, alongside the combinational ALU.
- Takes the same operand pair and 5-bit select code as the ALU, and owns DIV, DIVU, REM and REMU.
- Frees the ALU of its single-cycle divider.
- Asserts BUSY so the hazard/stall logic can freeze the ID/EX and EX/MEM registers until VALID.

---
 rtl/div_unit_pkg.sv | 31 +++
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit_step.sv | 21 ++
 rtl/div_unit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared types and operation codes for the iterative divide unit.
package div_unit_pkg;

  // Controller states; BUSY covers StCalc and StFix only.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_e;

  // Select codes shared with the ALU decode.
  localparam logic [4:0] SelAdd  = 5'd0;
  localparam logic [4:0] SelDiv  = 5'd16;
  localparam logic [4:0] SelDivu = 5'd17;
  localparam logic [4:0] SelRem  = 5'd18;
  localparam logic [4:0] SelRemu = 5'd19;

  function automatic logic is_div_op(input logic [4:0] sel);
    return (sel == SelDiv) || (sel == SelDivu) || (sel == SelRem) || (sel == SelRemu);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] sel);
    return (sel == SelDiv) || (sel == SelRem);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] sel);
    return (sel == SelRem) || (sel == SelRemu);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the divide unit.
interface div_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [4:0]      select;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            flush;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, select, data1, data2, flush,
    input  busy, valid, result
  );

  modport slave (
    input  start, select, data1, data2, flush,
    output busy, valid, result
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring shift/compare/subtract iteration of the unsigned divider.
module div_unit_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Partial remainder is one bit wider so the borrow lands in the MSB.
  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};
    rem_out = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  end
endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit: one quotient bit per cycle, sign fix-up at the end.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(XLEN);

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
  logic            neg_q, neg_d, sgn1_q, sgn1_d, rem_op_q, rem_op_d;

  logic [XLEN-1:0] step_rem, step_quo, a_abs, b_abs;
  logic            a_neg, b_neg, accept, div_zero, ovf;

  div_unit_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(dvs_q),
    .rem_out(step_rem),
    .quo_out(step_quo)
  );

  // Next-state, operand capture and result selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    neg_d    = neg_q;
    sgn1_d   = sgn1_q;
    rem_op_d = rem_op_q;
    result_d = result_q;

    a_neg    = is_signed_op(bus.select) & bus.data1[XLEN-1];
    b_neg    = is_signed_op(bus.select) & bus.data2[XLEN-1];
    a_abs    = a_neg ? -bus.data1 : bus.data1;
    b_abs    = b_neg ? -bus.data2 : bus.data2;
    div_zero = (bus.data2 == '0);
    ovf      = is_signed_op(bus.select) && (bus.data1 == {1'b1, {(XLEN-1){1'b0}}}) &&
               (bus.data2 == '1);
    accept   = ((state_q == StIdle) || (state_q == StDone)) && bus.start &&
               is_div_op(bus.select) && !bus.flush;

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          neg_d    = a_neg ^ b_neg;
          sgn1_d   = a_neg;
          rem_op_d = is_rem_op(bus.select);
          rem_d    = '0;
          quo_d    = a_abs;
          dvs_d    = b_abs;
          if (div_zero) begin
            state_d  = StDone;
            result_d = is_rem_op(bus.select) ? bus.data1 : '1;
          end else if (ovf) begin
            // Quotient saturates to the most negative value, remainder is zero.
            state_d  = StDone;
            result_d = is_rem_op(bus.select) ? '0 : bus.data1;
          end else begin
            state_d = StCalc;
            cnt_d   = CNT_W'(XLEN - 1);
          end
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = StFix;
      end
      StFix: begin
        state_d  = StDone;
        result_d = rem_op_q ? (sgn1_q ? -rem_q : rem_q) : (neg_q ? -quo_q : quo_q);
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything, including a same-cycle start; result is kept.
    if (bus.flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      sgn1_q   <= 1'b0;
      rem_op_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      neg_q    <= neg_d;
      sgn1_q   <= sgn1_d;
      rem_op_q <= rem_op_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == StCalc) || (state_q == StFix);
  assign bus.valid  = (state_q == StDone);
  assign bus.result = result_q;
endmodule
